// File: rtl/noc_params.sv
// Shared NoC types and constants for the virtual-channel input buffer.
// Flit layout, flit labels, per-VC FSM states and small label helpers.
package noc_params;

   localparam int unsigned VC_NUM      = 2;
   // Keep at least one bit so a single-VC build still has a legal vc field.
   localparam int unsigned VC_SIZE     = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
   localparam int unsigned FLIT_DATA_W = 16;

   typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;

   typedef struct packed {
      flit_label_t            flit_label;
      logic [FLIT_DATA_W-1:0] payload;
   } flit_t;

   typedef enum logic [1:0] {IDLE, VA, ACTIVE} vc_state_t;

   function automatic logic is_head(flit_label_t label);
      return (label == HEAD) || (label == HEADTAIL);
   endfunction

   function automatic logic is_tail(flit_label_t label);
      return (label == TAIL) || (label == HEADTAIL);
   endfunction

endpackage

// File: rtl/vc_input_buffer_if.sv
// Link-side and allocator-side signals of the VC input buffer, seen from the buffer.
// Optional occupancy_o exists only when VC_INPUT_BUFFER_OCCUPANCY_EN is defined.
interface vc_input_buffer_if #(
   parameter int unsigned BUFFER_SIZE = 8
) ();
   import noc_params::*;

   localparam int unsigned OCC_W = $clog2(BUFFER_SIZE + 1);

   flit_t               data_i;
   logic                valid_i;
   logic [VC_SIZE-1:0]  vc_i;
   logic                read_i;
   logic [VC_SIZE-1:0]  read_vc_i;
   logic [VC_NUM-1:0]   va_grant_i;
   flit_t               data_o;
   logic [VC_NUM-1:0]   is_full_o;
   logic [VC_NUM-1:0]   is_empty_o;
   logic [VC_NUM-1:0]   va_req_o;
   logic [VC_NUM-1:0]   sa_req_o;
   logic                overflow_o;
`ifdef VC_INPUT_BUFFER_OCCUPANCY_EN
   logic [VC_NUM-1:0][OCC_W-1:0] occupancy_o;
`endif

   modport slave (
      input  data_i,
      input  valid_i,
      input  vc_i,
      input  read_i,
      input  read_vc_i,
      input  va_grant_i,
      output data_o,
      output is_full_o,
      output is_empty_o,
      output va_req_o,
      output sa_req_o,
      output overflow_o
`ifdef VC_INPUT_BUFFER_OCCUPANCY_EN
      ,
      output occupancy_o
`endif
   );

   modport master (
      output data_i,
      output valid_i,
      output vc_i,
      output read_i,
      output read_vc_i,
      output va_grant_i,
      input  data_o,
      input  is_full_o,
      input  is_empty_o,
      input  va_req_o,
      input  sa_req_o,
      input  overflow_o
`ifdef VC_INPUT_BUFFER_OCCUPANCY_EN
      ,
      input  occupancy_o
`endif
   );

endinterface

// File: rtl/circular_buffer.sv
// Single-VC flit FIFO with wrap-bit pointers; front flit reads as zero when empty.
// VC_INPUT_BUFFER_OCCUPANCY_EN adds a registered flit counter output.
module circular_buffer
   import noc_params::*;
#(
   parameter int unsigned BUFFER_SIZE = 8
) (
   input  logic  clk,
   input  logic  rst,
   input  flit_t data_i,
   input  logic  write_i,
   input  logic  read_i,
   output flit_t data_o,
   output logic  is_full_o,
   output logic  is_empty_o
`ifdef VC_INPUT_BUFFER_OCCUPANCY_EN
   ,
   output logic [$clog2(BUFFER_SIZE+1)-1:0] occupancy_o
`endif
);

   localparam int unsigned PTR_W = $clog2(BUFFER_SIZE);
   localparam logic [PTR_W:0] PtrOne = {{PTR_W{1'b0}}, 1'b1};

   logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
   flit_t          mem_q [BUFFER_SIZE];
   logic           do_read, do_write;

   assign is_empty_o = (rd_ptr_q == wr_ptr_q);
   assign is_full_o  = (rd_ptr_q[PTR_W] != wr_ptr_q[PTR_W]) &&
                       (rd_ptr_q[PTR_W-1:0] == wr_ptr_q[PTR_W-1:0]);

   // A full FIFO may still accept a write when the front slot is freed in the same cycle.
   assign do_read  = read_i && !is_empty_o;
   assign do_write = write_i && (!is_full_o || do_read);

   assign data_o = is_empty_o ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      if (do_read)  rd_ptr_d = rd_ptr_q + PtrOne;
      if (do_write) wr_ptr_d = wr_ptr_q + PtrOne;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_write) mem_q[wr_ptr_q[PTR_W-1:0]] <= data_i;
   end

`ifdef VC_INPUT_BUFFER_OCCUPANCY_EN
   localparam int unsigned OCC_W = $clog2(BUFFER_SIZE + 1);
   logic [OCC_W-1:0] occ_q, occ_d;

   always_comb begin
      occ_d = occ_q;
      if (do_write && !do_read)      occ_d = occ_q + OCC_W'(1);
      else if (do_read && !do_write) occ_d = occ_q - OCC_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) occ_q <= '0;
      else     occ_q <= occ_d;
   end

   assign occupancy_o = occ_q;
`endif

endmodule

// File: rtl/vc_input_buffer.sv
// Router input port: per-VC flit FIFO plus IDLE/VA/ACTIVE control FSM, write demux and read mux.
// Define VC_INPUT_BUFFER_OCCUPANCY_EN to expose per-VC occupancy counters.
module vc_input_buffer
   import noc_params::*;
#(
   parameter int unsigned BUFFER_SIZE = 8
) (
   input logic               clk,
   input logic               rst,
   vc_input_buffer_if.slave  bus
);

   localparam int unsigned OCC_W = $clog2(BUFFER_SIZE + 1);

   flit_t             front [VC_NUM];
   logic [VC_NUM-1:0] full, empty, push, pop, drop, va_req, sa_req;
   logic              overflow_q, overflow_d;
   flit_t             data_mux;
`ifdef VC_INPUT_BUFFER_OCCUPANCY_EN
   logic [VC_NUM-1:0][OCC_W-1:0] occ;
`endif

   for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
      vc_state_t state_q, state_d;
      logic      va_req_l, sa_req_l;
      logic      sel_wr;

      assign sel_wr  = bus.valid_i && (bus.vc_i == VC_SIZE'(v));
      assign pop[v]  = bus.read_i && (bus.read_vc_i == VC_SIZE'(v)) &&
                       (state_q == ACTIVE) && !empty[v];
      assign push[v] = sel_wr && (!full[v] || pop[v]);
      assign drop[v] = sel_wr && full[v] && !pop[v];

      circular_buffer #(
         .BUFFER_SIZE (BUFFER_SIZE)
      ) u_buf (
         .clk         (clk),
         .rst         (rst),
         .data_i      (bus.data_i),
         .write_i     (push[v]),
         .read_i      (pop[v]),
         .data_o      (front[v]),
         .is_full_o   (full[v]),
         .is_empty_o  (empty[v])
`ifdef VC_INPUT_BUFFER_OCCUPANCY_EN
         ,
         .occupancy_o (occ[v])
`endif
      );

      always_ff @(posedge clk or posedge rst) begin
         if (rst) state_q <= IDLE;
         else     state_q <= state_d;
      end

      // A body/tail flit at the front of an idle VC is a protocol error: it stays put.
      always_comb begin
         state_d = state_q;
         unique case (state_q)
            IDLE:    if (!empty[v] && is_head(front[v].flit_label)) state_d = VA;
            VA:      if (bus.va_grant_i[v]) state_d = ACTIVE;
            ACTIVE:  if (pop[v] && is_tail(front[v].flit_label)) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end

      always_comb begin
         va_req_l = 1'b0;
         sa_req_l = 1'b0;
         unique case (state_q)
            VA:      va_req_l = 1'b1;
            ACTIVE:  sa_req_l = !empty[v];
            default: ;
         endcase
      end

      assign va_req[v] = va_req_l;
      assign sa_req[v] = sa_req_l;
   end

   always_comb begin
      data_mux = '0;
      for (int unsigned v = 0; v < VC_NUM; v++) begin
         if (bus.read_vc_i == VC_SIZE'(v)) data_mux = front[v];
      end
   end

   assign overflow_d = overflow_q | (|drop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) overflow_q <= 1'b0;
      else     overflow_q <= overflow_d;
   end

   assign bus.data_o     = data_mux;
   assign bus.is_full_o  = full;
   assign bus.is_empty_o = empty;
   assign bus.va_req_o   = va_req;
   assign bus.sa_req_o   = sa_req;
   assign bus.overflow_o = overflow_q;
`ifdef VC_INPUT_BUFFER_OCCUPANCY_EN
   assign bus.occupancy_o = occ;
`endif

endmodule
